alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Consumer end of the ALU result interface.
- Accepts one ALU result per handshake: out, r0, overflow_flag, ctrl, destination register.
- Sequences register-file writes through a single write port. MUL and DIV need two writes: rd, then R0 for the high product or remainder.
- Converts overflow and divide-by-zero into a held exception request toward the control unit.

Parameters:
- DATA_W, 16, ALU data width.
- REG_AW, 4, register-file address width.
- R0_ADDR, 0, register receiving the MUL high half or DIV remainder.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  ALU result valid.
- in_ready  output  1  block can accept a result this cycle.
- alu_out  input  DATA_W  ALU primary result.
- alu_r0  input  DATA_W  ALU secondary result (MUL high, DIV remainder).
- alu_ovf  input  1  ALU overflow_flag.
- alu_ctrl  input  4  ALU op code.
- div_zero  input  1  divisor was zero.
- rd  input  REG_AW  destination register.
- pc  input  DATA_W  PC of the instruction.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  REG_AW  write address.
- rf_wdata  output  DATA_W  write data.
- exc_valid  output  1  exception pending.
- exc_code  output  2  01 overflow, 10 divide-by-zero.
- exc_epc  output  DATA_W  PC of the faulting instruction.
- exc_ack  input  1  control unit accepts the exception.

Behaviour:
- Op codes: 1 ADD, 2 SUB, 4 MUL, 8 DIV, C ANDI, E ORI, F ADD-no-func. Any other code is NOP: accepted, no write.
- Checked ops (alu_ovf honoured): 1, 2, 4, 8, F. C and E ignore alu_ovf.
- Two-write ops: 4, 8.
- Handshake: transfer occurs when in_valid and in_ready are both high. Inputs are captured into internal registers on transfer, so sources may change afterward.
- States: IDLE, WR_RD, WR_R0, EXC.
- On transfer, the next state is chosen in priority order:
  - EXC if op 8 and div_zero (code 10), else
  - EXC if a checked op and alu_ovf (code 01), else
  - IDLE if NOP, else
  - WR_RD.
- WR_RD: rf_we=1, rf_waddr=captured rd, rf_wdata=captured out. Goes to WR_R0 if a two-write op, else terminal.
- WR_R0: rf_we=1, rf_waddr=R0_ADDR, rf_wdata=captured r0. Terminal.
- Terminal states (WR_RD for single-write ops, WR_R0):
  - in_ready=1, so a back-to-back transfer is allowed.
  - With a new transfer, the next state is chosen by the rules above; otherwise go to IDLE.
- IDLE: in_ready=1, rf_we=0.
- Latency: transfer at cycle N gives the rd write at N+1 and the R0 write at N+2. Sustained single-write throughput is one result per cycle.
- EXC:
  - exc_valid=1; exc_code and exc_epc hold the captured values; in_ready=0; no register writes.
  - Stays in EXC until exc_ack, then IDLE the following cycle.
  - exc_ack outside EXC is ignored.
- The faulting op writes nothing: rd is not written, and R0 is not written for a faulting MUL/DIV.
- rd == R0_ADDR on MUL/DIV: both writes occur in order, so the R0 value wins.
- rf_we, rf_waddr and rf_wdata are registered from state, with no combinational path from inputs. in_ready is decoded from state only.
- Reset (any cycle, including mid-sequence or in EXC):
  - state=IDLE; rf_we=0, rf_waddr=0, rf_wdata=0; exc_valid=0, exc_code=0, exc_epc=0; all capture registers 0.
  - in_ready=1 from the first cycle after reset deasserts.
  - A pending R0 write or exception is discarded.

Optional Feature:
- Macro: ALU_WB_STATS_EN.
- With the macro defined:
  - Adds output ports exc_count[7:0] and wr_count[15:0], both reset to 0.
  - exc_count increments on each entry to EXC and saturates at 255.
  - wr_count increments on every rf_we cycle and wraps.
- Without the macro: neither port nor either counter exists; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - op-code localparams: OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_ANDI, OP_ORI, OP_ADDNF;
  - exception codes: EXC_OVF, EXC_DZ;
  - the wb_state_t state encoding.
- The same package is shared with the ALU and the control unit.
- One sub-module, alu_op_classify: combinational; maps ctrl to is_checked, is_two_write, is_nop.

Test Plan:
- ADD (ctrl=1), out=0x0005, rd=3, no ovf → cycle N+1: rf_we=1, addr 3, data 0x0005; in_ready stays 1.
- MUL (ctrl=4), out=0x1234, r0=0x0001, rd=5 → N+1 write r5=0x1234; N+2 write r0=0x0001; in_ready=0 at N+1 only.
- DIV (ctrl=8) with div_zero=1, pc=0x0040 → EXC: exc_valid=1, code 10, epc 0x0040, no rf_we. Hold 3 cycles, pulse exc_ack → IDLE next cycle with in_ready=1.
- ANDI (ctrl=C) with alu_ovf=1, out=0x00F0, rd=2 → normal write r2=0x00F0, no exception.
- Back-to-back: ADD rd=1 then SUB rd=2 on consecutive cycles → writes on consecutive cycles. Then MUL with rd=0 → r0 written twice, second value alu_r0.
- Assert reset low while in WR_RD of a MUL → next cycle state IDLE, rf_we=0, all outputs 0, and no R0 write afterward.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, exception codes and the writeback state encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_MUL   = 4'h4;
  localparam logic [3:0] OP_DIV   = 4'h8;
  localparam logic [3:0] OP_ANDI  = 4'hC;
  localparam logic [3:0] OP_ORI   = 4'hE;
  localparam logic [3:0] OP_ADDNF = 4'hF;

  localparam logic [1:0] EXC_OVF = 2'b01;
  localparam logic [1:0] EXC_DZ  = 2'b10;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_WR_RD = 2'd1,
    WB_WR_R0 = 2'd2,
    WB_EXC   = 2'd3
  } wb_state_t;

endpackage

// File: rtl/alu_op_classify.sv
// Decodes an ALU op code into the attributes the writeback sequencer needs.
module alu_op_classify
  import alu_pkg::*;
(
  input  logic [3:0] ctrl,
  output logic       is_checked,
  output logic       is_two_write,
  output logic       is_nop
);

  always_comb begin
    is_checked   = 1'b0;
    is_two_write = 1'b0;
    is_nop       = 1'b0;
    case (ctrl)
      OP_ADD, OP_SUB, OP_ADDNF: is_checked = 1'b1;
      OP_MUL, OP_DIV: begin
        is_checked   = 1'b1;
        is_two_write = 1'b1;
      end
      OP_ANDI, OP_ORI: ;
      default: is_nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU result consumer: sequences register-file writes and raises held exceptions.
// Optional statistics counters are enabled with the ALU_WB_STATS_EN macro.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 4,
  parameter int R0_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] alu_r0,
  input  logic              alu_ovf,
  input  logic [3:0]        alu_ctrl,
  input  logic              div_zero,
  input  logic [REG_AW-1:0] rd,
  input  logic [DATA_W-1:0] pc,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              exc_valid,
  output logic [1:0]        exc_code,
  output logic [DATA_W-1:0] exc_epc,
  input  logic              exc_ack
`ifdef ALU_WB_STATS_EN
  ,
  output logic [7:0]        exc_count,
  output logic [15:0]       wr_count
`endif
);

  wb_state_t         state;
  logic [DATA_W-1:0] cap_r0;
  logic              cap_two;
  logic              is_checked;
  logic              is_two_write;
  logic              is_nop;
  logic              dz_fault;
  logic              ovf_fault;

  alu_op_classify u_classify (
    .ctrl        (alu_ctrl),
    .is_checked  (is_checked),
    .is_two_write(is_two_write),
    .is_nop      (is_nop)
  );

  assign dz_fault  = (alu_ctrl == OP_DIV) && div_zero;
  assign ovf_fault = is_checked && alu_ovf;

  // Ready everywhere except EXC and the first half of a two-write sequence.
  assign in_ready = (state != WB_EXC) && !((state == WB_WR_RD) && cap_two);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= WB_IDLE;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      exc_valid <= 1'b0;
      exc_code  <= '0;
      exc_epc   <= '0;
      cap_r0    <= '0;
      cap_two   <= 1'b0;
`ifdef ALU_WB_STATS_EN
      exc_count <= '0;
      wr_count  <= '0;
`endif
    end else begin
      rf_we <= 1'b0;
`ifdef ALU_WB_STATS_EN
      if (rf_we) wr_count <= wr_count + 16'd1;
`endif
      case (state)
        WB_EXC: begin
          if (exc_ack) begin
            state     <= WB_IDLE;
            exc_valid <= 1'b0;
          end
        end
        default: begin
          if ((state == WB_WR_RD) && cap_two) begin
            state    <= WB_WR_R0;
            rf_we    <= 1'b1;
            rf_waddr <= REG_AW'(R0_ADDR);
            rf_wdata <= cap_r0;
          end else if (in_valid) begin
            cap_r0  <= alu_r0;
            cap_two <= 1'b0;
            // Divide-by-zero outranks overflow; a faulting op writes nothing.
            if (dz_fault || ovf_fault) begin
              state     <= WB_EXC;
              exc_valid <= 1'b1;
              exc_code  <= dz_fault ? EXC_DZ : EXC_OVF;
              exc_epc   <= pc;
`ifdef ALU_WB_STATS_EN
              if (exc_count != 8'hFF) exc_count <= exc_count + 8'd1;
`endif
            end else if (is_nop) begin
              state <= WB_IDLE;
            end else begin
              state    <= WB_WR_RD;
              rf_we    <= 1'b1;
              rf_waddr <= rd;
              rf_wdata <= alu_out;
              cap_two  <= is_two_write;
            end
          end else begin
            state <= WB_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: queue-based write model plus directed literal checks.
module tb_alu_writeback;

  localparam int DATA_W  = 16;
  localparam int REG_AW  = 4;
  localparam int R0_ADDR = 0;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] alu_out = '0;
  logic [DATA_W-1:0] alu_r0 = '0;
  logic              alu_ovf = 1'b0;
  logic [3:0]        alu_ctrl = '0;
  logic              div_zero = 1'b0;
  logic [REG_AW-1:0] rd = '0;
  logic [DATA_W-1:0] pc = '0;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              exc_valid;
  logic [1:0]        exc_code;
  logic [DATA_W-1:0] exc_epc;
  logic              exc_ack = 1'b0;
`ifdef ALU_WB_STATS_EN
  logic [7:0]        exc_count;
  logic [15:0]       wr_count;
`endif

  always #5 clk = ~clk;

  alu_writeback #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .R0_ADDR(R0_ADDR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_out  (alu_out),
    .alu_r0   (alu_r0),
    .alu_ovf  (alu_ovf),
    .alu_ctrl (alu_ctrl),
    .div_zero (div_zero),
    .rd       (rd),
    .pc       (pc),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .exc_valid(exc_valid),
    .exc_code (exc_code),
    .exc_epc  (exc_epc),
    .exc_ack  (exc_ack)
`ifdef ALU_WB_STATS_EN
    ,
    .exc_count(exc_count),
    .wr_count (wr_count)
`endif
  );

  typedef struct packed {
    logic [REG_AW-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  // Model: writes still owed to the register file, in order, one per cycle.
  wr_t               pend[$];
  bit                m_exc = 1'b0;
  logic [1:0]        m_code = '0;
  logic [DATA_W-1:0] m_epc = '0;
  bit                e_we = 1'b0;
  logic [REG_AW-1:0] e_addr = '0;
  logic [DATA_W-1:0] e_data = '0;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    wr_t w;
    if (!reset) begin
      pend.delete();
      m_exc = 1'b0;
      e_we  = 1'b0;
      return;
    end
    if (m_exc) begin
      if (exc_ack) m_exc = 1'b0;
    end else if (pend.size() == 0 && in_valid) begin
      if (alu_ctrl == 4'h8 && div_zero) begin
        m_exc = 1'b1; m_code = 2'b10; m_epc = pc;
      end else if (alu_ovf && (alu_ctrl inside {4'h1, 4'h2, 4'h4, 4'h8, 4'hF})) begin
        m_exc = 1'b1; m_code = 2'b01; m_epc = pc;
      end else if (alu_ctrl inside {4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hE, 4'hF}) begin
        w.a = rd; w.d = alu_out;
        pend.push_back(w);
        if (alu_ctrl inside {4'h4, 4'h8}) begin
          w.a = REG_AW'(R0_ADDR); w.d = alu_r0;
          pend.push_back(w);
        end
      end
    end
    e_we = 1'b0;
    if (pend.size() > 0) begin
      w = pend.pop_front();
      e_we = 1'b1; e_addr = w.a; e_data = w.d;
    end
  endtask

  task automatic compare();
    check("in_ready", 32'(in_ready), 32'(!m_exc && pend.size() == 0));
    check("rf_we", 32'(rf_we), 32'(e_we));
    if (e_we) begin
      check("rf_waddr", 32'(rf_waddr), 32'(e_addr));
      check("rf_wdata", 32'(rf_wdata), 32'(e_data));
    end
    check("exc_valid", 32'(exc_valid), 32'(m_exc));
    if (m_exc) begin
      check("exc_code", 32'(exc_code), 32'(m_code));
      check("exc_epc", 32'(exc_epc), 32'(m_epc));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic drive(input logic [3:0] c, input logic [15:0] o, input logic [15:0] r,
                       input logic ov, input logic dz, input logic [3:0] d, input logic [15:0] p);
    in_valid = 1'b1; alu_ctrl = c; alu_out = o; alu_r0 = r;
    alu_ovf = ov; div_zero = dz; rd = d; pc = p;
  endtask

  task automatic idle();
    in_valid = 1'b0; alu_ctrl = '0; alu_out = '0; alu_r0 = '0;
    alu_ovf = 1'b0; div_zero = 1'b0; rd = '0; pc = '0;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    tick(); tick();
    check("rst_we", 32'(rf_we), 32'(0));
    check("rst_waddr", 32'(rf_waddr), 32'(0));
    check("rst_wdata", 32'(rf_wdata), 32'(0));
    check("rst_exc_valid", 32'(exc_valid), 32'(0));
    check("rst_exc_code", 32'(exc_code), 32'(0));
    check("rst_exc_epc", 32'(exc_epc), 32'(0));
    reset = 1'b1;
    tick();
    check("post_rst_ready", 32'(in_ready), 32'(1));

    // ADD r3 = 0x0005
    drive(4'h1, 16'h0005, 16'h0000, 1'b0, 1'b0, 4'd3, 16'h0010);
    tick();
    check("add_we", 32'(rf_we), 32'(1));
    check("add_addr", 32'(rf_waddr), 32'(3));
    check("add_data", 32'(rf_wdata), 32'h0005);
    check("add_ready", 32'(in_ready), 32'(1));
    idle(); tick();
    check("add_done_we", 32'(rf_we), 32'(0));

    // MUL r5 = 0x1234, R0 = 0x0001
    drive(4'h4, 16'h1234, 16'h0001, 1'b0, 1'b0, 4'd5, 16'h0014);
    tick();
    check("mul_rd_addr", 32'(rf_waddr), 32'(5));
    check("mul_rd_data", 32'(rf_wdata), 32'h1234);
    check("mul_ready_n1", 32'(in_ready), 32'(0));
    idle(); tick();
    check("mul_r0_we", 32'(rf_we), 32'(1));
    check("mul_r0_addr", 32'(rf_waddr), 32'(0));
    check("mul_r0_data", 32'(rf_wdata), 32'h0001);
    check("mul_ready_n2", 32'(in_ready), 32'(1));
    tick();

    // DIV by zero -> held exception, ignores new results until acked
    drive(4'h8, 16'h0007, 16'h0003, 1'b0, 1'b1, 4'd6, 16'h0040);
    tick();
    check("dz_valid", 32'(exc_valid), 32'(1));
    check("dz_code", 32'(exc_code), 32'h2);
    check("dz_epc", 32'(exc_epc), 32'h0040);
    check("dz_we", 32'(rf_we), 32'(0));
    drive(4'h1, 16'h0099, 16'h0000, 1'b0, 1'b0, 4'd7, 16'h0044);
    tick(); tick(); tick();
    check("dz_hold_valid", 32'(exc_valid), 32'(1));
    check("dz_hold_epc", 32'(exc_epc), 32'h0040);
    idle(); exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    check("dz_ack_valid", 32'(exc_valid), 32'(0));
    check("dz_ack_ready", 32'(in_ready), 32'(1));
    tick();

    // ANDI ignores overflow
    drive(4'hC, 16'h00F0, 16'h0000, 1'b1, 1'b0, 4'd2, 16'h0048);
    tick();
    check("andi_addr", 32'(rf_waddr), 32'(2));
    check("andi_data", 32'(rf_wdata), 32'h00F0);
    check("andi_exc", 32'(exc_valid), 32'(0));

    // back-to-back ADD, SUB, then MUL into R0
    drive(4'h1, 16'h0011, 16'h0000, 1'b0, 1'b0, 4'd1, 16'h004C);
    tick();
    check("b2b_add_addr", 32'(rf_waddr), 32'(1));
    drive(4'h2, 16'h0022, 16'h0000, 1'b0, 1'b0, 4'd2, 16'h0050);
    tick();
    check("b2b_sub_we", 32'(rf_we), 32'(1));
    check("b2b_sub_data", 32'(rf_wdata), 32'h0022);
    drive(4'h4, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 4'd0, 16'h0054);
    tick();
    check("mul0_first", 32'(rf_wdata), 32'hAAAA);
    idle(); tick();
    check("mul0_second_addr", 32'(rf_waddr), 32'(0));
    check("mul0_second_data", 32'(rf_wdata), 32'h5555);
    tick();

    // ack outside EXC is ignored; ADD overflow raises code 01
    exc_ack = 1'b1; tick(); exc_ack = 1'b0;
    drive(4'h1, 16'h8000, 16'h0000, 1'b1, 1'b0, 4'd4, 16'h0058);
    tick();
    check("ovf_valid", 32'(exc_valid), 32'(1));
    check("ovf_code", 32'(exc_code), 32'h1);
    check("ovf_epc", 32'(exc_epc), 32'h0058);
    idle(); exc_ack = 1'b1; tick(); exc_ack = 1'b0;

    // divide-by-zero outranks overflow
    drive(4'h8, 16'h0001, 16'h0001, 1'b1, 1'b1, 4'd8, 16'h005C);
    tick();
    check("dz_prio_code", 32'(exc_code), 32'h2);
    idle(); exc_ack = 1'b1; tick(); exc_ack = 1'b0;

    // NOP, ORI with ovf, ADD-no-func overflow, MUL overflow
    drive(4'h3, 16'h0123, 16'h0000, 1'b0, 1'b0, 4'd9, 16'h0060); tick();
    check("nop_we", 32'(rf_we), 32'(0));
    drive(4'hE, 16'h0F0F, 16'h0000, 1'b1, 1'b0, 4'd10, 16'h0064); tick();
    check("ori_data", 32'(rf_wdata), 32'h0F0F);
    drive(4'hF, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 4'd11, 16'h0068); tick();
    check("addnf_code", 32'(exc_code), 32'h1);
    idle(); exc_ack = 1'b1; tick(); exc_ack = 1'b0;
    drive(4'h4, 16'h4444, 16'h3333, 1'b1, 1'b0, 4'd12, 16'h006C); tick();
    check("mul_ovf_we", 32'(rf_we), 32'(0));
    idle(); exc_ack = 1'b1; tick(); exc_ack = 1'b0; tick();
    check("mul_ovf_no_r0", 32'(rf_we), 32'(0));

    // reset during the rd write of a MUL drops the R0 write
    drive(4'h4, 16'h0BAD, 16'h0DAD, 1'b0, 1'b0, 4'd9, 16'h0070);
    tick();
    idle(); reset = 1'b0; tick();
    check("mid_rst_we", 32'(rf_we), 32'(0));
    check("mid_rst_waddr", 32'(rf_waddr), 32'(0));
    check("mid_rst_wdata", 32'(rf_wdata), 32'(0));
    reset = 1'b1; tick();
    check("mid_rst_no_r0", 32'(rf_we), 32'(0));

    // reset while in EXC discards the exception
    drive(4'h8, 16'h0000, 16'h0000, 1'b0, 1'b1, 4'd1, 16'h0074); tick();
    idle(); reset = 1'b0; tick();
    check("exc_rst_valid", 32'(exc_valid), 32'(0));
    check("exc_rst_epc", 32'(exc_epc), 32'(0));
    reset = 1'b1; tick();

    // mixed traffic against the model
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'(($urandom % 4) != 0);
      alu_ctrl = 4'($urandom);
      alu_out  = 16'($urandom);
      alu_r0   = 16'($urandom);
      alu_ovf  = 1'(($urandom % 4) == 0);
      div_zero = 1'(($urandom % 4) == 0);
      rd       = 4'($urandom);
      pc       = 16'($urandom);
      exc_ack  = 1'(($urandom % 3) == 0);
      reset    = 1'(($urandom % 60) != 0);
      tick();
    end
    idle(); exc_ack = 1'b0; reset = 1'b1;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
